// File: rtl/nl_ctrl_pkg.sv
// nl_ctrl_pkg: shared definitions for the nolinear sequencer.
// Op encodings, FSM state enum, the packed datapath control word and the
// per-(op, round) control-word constants.
package nl_ctrl_pkg;

  // Command op encodings
  localparam logic [1:0] OP_SOFTMAX = 2'b00;
  localparam logic [1:0] OP_GELU    = 2'b01;
  localparam logic [1:0] OP_ROOT    = 2'b10;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_R1   = 2'd1,
    ST_R2   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Field order matches the datapath control listing: mode first, valid last.
  typedef struct packed {
    logic [1:0] mode;
    logic [2:0] s_in;
    logic       s_mux;
    logic [2:0] s_mult;
    logic       s_add;
    logic       en_mult;
    logic       en_add;
    logic       valid;
  } ctrl_word_t;

  localparam ctrl_word_t CW_IDLE       = '{2'b00, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam ctrl_word_t CW_SOFTMAX_R1 = '{2'b00, 3'd0, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam ctrl_word_t CW_SOFTMAX_R2 = '{2'b00, 3'd1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam ctrl_word_t CW_GELU_R1    = '{2'b01, 3'd2, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam ctrl_word_t CW_GELU_R2    = '{2'b01, 3'd3, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1};
  localparam ctrl_word_t CW_ROOT_R1    = '{2'b10, 3'd2, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0, 1'b1};

  // Softmax and GELU/SiLU need a second round; root finishes after R1.
  function automatic logic is_two_round(input logic [1:0] op);
    return (op == OP_SOFTMAX) || (op == OP_GELU);
  endfunction

endpackage

// File: rtl/nl_ctrl_rom.sv
// nl_ctrl_rom: combinational (op, round) -> datapath control word lookup.
// round = 0 selects R1, round = 1 selects R2. Combinations with no round
// (root R2, illegal op) return the idle word.
import nl_ctrl_pkg::*;

module nl_ctrl_rom (
  input  logic [1:0] op,
  input  logic       round,
  output ctrl_word_t word
);

  // Table lookup; anything unlisted drives the datapath idle.
  always_comb begin
    word = CW_IDLE;
    case ({op, round})
      {OP_SOFTMAX, 1'b0}: word = CW_SOFTMAX_R1;
      {OP_SOFTMAX, 1'b1}: word = CW_SOFTMAX_R2;
      {OP_GELU,    1'b0}: word = CW_GELU_R1;
      {OP_GELU,    1'b1}: word = CW_GELU_R2;
      {OP_ROOT,    1'b0}: word = CW_ROOT_R1;
      default:            word = CW_IDLE;
    endcase
  end

endmodule

// File: rtl/nolinear_ctrl.sv
// nolinear_ctrl: command sequencer for the nolinear datapath.
// Accepts one op per command, walks the datapath through one or two timed
// rounds, captures dp_out at the end of the final round and holds it on a
// valid/ready result port.
// Optional feature macro: NL_CTRL_ABORT_EN adds an 'abort' input that
// cancels a running op (R1/R2) or drops a pending result (DONE).
import nl_ctrl_pkg::*;

module nolinear_ctrl #(
  parameter int FIX_POINT_WIDTH = 16,
  parameter int DATA_NUM        = 4,
  parameter int R1_CYCLES       = 50,
  parameter int R2_CYCLES       = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cmd_valid,
  output logic                                cmd_ready,
  input  logic [1:0]                          cmd_op,
  input  logic [DATA_NUM*FIX_POINT_WIDTH-1:0] cmd_data,
  output logic [1:0]                          dp_mode,
  output logic [DATA_NUM*FIX_POINT_WIDTH-1:0] dp_in,
  output logic [2:0]                          dp_s_in,
  output logic                                dp_s_mux,
  output logic [2:0]                          dp_s_mult,
  output logic                                dp_s_add,
  output logic                                dp_en_mult,
  output logic                                dp_en_add,
  output logic                                dp_valid,
  input  logic [DATA_NUM*FIX_POINT_WIDTH-1:0] dp_out,
  output logic                                res_valid,
  input  logic                                res_ready,
  output logic [DATA_NUM*FIX_POINT_WIDTH-1:0] res_data,
  output logic                                res_err
`ifdef NL_CTRL_ABORT_EN
  ,
  input  logic                                abort
`endif
);

  localparam int VEC_W   = DATA_NUM * FIX_POINT_WIDTH;
  localparam int CNT_MAX = (R1_CYCLES > R2_CYCLES) ? R1_CYCLES : R2_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] R1_LOAD = CNT_W'(R1_CYCLES - 1);
  localparam logic [CNT_W-1:0] R2_LOAD = CNT_W'(R2_CYCLES - 1);

  state_e            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [1:0]        op_reg, op_next;
  logic [VEC_W-1:0]  in_reg, in_next;
  ctrl_word_t        ctrl_reg, ctrl_next;
  logic              res_valid_reg, res_valid_next;
  logic              res_err_reg, res_err_next;
  logic [VEC_W-1:0]  res_data_reg, res_data_next;

  logic              abort_hit;
  logic [1:0]        rom_op;
  logic              rom_round;
  ctrl_word_t        rom_word;

`ifdef NL_CTRL_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  // In IDLE the ROM looks ahead to the incoming op's R1 word; in R1 it
  // looks ahead to the latched op's R2 word, ready for the round change.
  assign rom_op    = (state_reg == ST_IDLE) ? cmd_op : op_reg;
  assign rom_round = (state_reg == ST_R1);

  nl_ctrl_rom u_rom (
    .op    (rom_op),
    .round (rom_round),
    .word  (rom_word)
  );

  // Only cmd_ready is combinational; forced low while reset is held.
  assign cmd_ready = rst && (state_reg == ST_IDLE);

  assign dp_mode    = ctrl_reg.mode;
  assign dp_s_in    = ctrl_reg.s_in;
  assign dp_s_mux   = ctrl_reg.s_mux;
  assign dp_s_mult  = ctrl_reg.s_mult;
  assign dp_s_add   = ctrl_reg.s_add;
  assign dp_en_mult = ctrl_reg.en_mult;
  assign dp_en_add  = ctrl_reg.en_add;
  assign dp_valid   = ctrl_reg.valid;
  assign dp_in      = in_reg;
  assign res_valid  = res_valid_reg;
  assign res_err    = res_err_reg;
  assign res_data   = res_data_reg;

  // State register and all registered outputs; reset drops any operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      op_reg        <= OP_SOFTMAX;
      in_reg        <= '0;
      ctrl_reg      <= CW_IDLE;
      res_valid_reg <= 1'b0;
      res_err_reg   <= 1'b0;
      res_data_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      op_reg        <= op_next;
      in_reg        <= in_next;
      ctrl_reg      <= ctrl_next;
      res_valid_reg <= res_valid_next;
      res_err_reg   <= res_err_next;
      res_data_reg  <= res_data_next;
    end
  end

  // Next-state, round counter, control word and result capture.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    op_next        = op_reg;
    in_next        = in_reg;
    ctrl_next      = ctrl_reg;
    res_valid_next = res_valid_reg;
    res_err_next   = res_err_reg;
    res_data_next  = res_data_reg;

    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_next = cmd_op;
          in_next = cmd_data;
          if (cmd_op == OP_ILLEGAL) begin
            state_next     = ST_DONE;
            ctrl_next      = CW_IDLE;
            res_valid_next = 1'b1;
            res_err_next   = 1'b1;
            res_data_next  = '0;
          end else begin
            state_next = ST_R1;
            cnt_next   = R1_LOAD;
            ctrl_next  = rom_word;
          end
        end
      end

      ST_R1: begin
        if (abort_hit) begin
          state_next = ST_IDLE;
          ctrl_next  = CW_IDLE;
        end else if (cnt_reg != '0) begin
          cnt_next = cnt_reg - 1'b1;
        end else if (is_two_round(op_reg)) begin
          state_next = ST_R2;
          cnt_next   = R2_LOAD;
          ctrl_next  = rom_word;
        end else begin
          // Root: R1 is the final round.
          state_next     = ST_DONE;
          ctrl_next      = CW_IDLE;
          res_valid_next = 1'b1;
          res_err_next   = 1'b0;
          res_data_next  = dp_out;
        end
      end

      ST_R2: begin
        if (abort_hit) begin
          state_next = ST_IDLE;
          ctrl_next  = CW_IDLE;
        end else if (cnt_reg != '0) begin
          cnt_next = cnt_reg - 1'b1;
        end else begin
          state_next     = ST_DONE;
          ctrl_next      = CW_IDLE;
          res_valid_next = 1'b1;
          res_err_next   = 1'b0;
          res_data_next  = dp_out;
        end
      end

      ST_DONE: begin
        if (abort_hit || res_ready) begin
          state_next     = ST_IDLE;
          res_valid_next = 1'b0;
        end
      end

      default: begin
        state_next = ST_IDLE;
        ctrl_next  = CW_IDLE;
      end
    endcase
  end

endmodule

// File: doc/nolinear_ctrl.md
# nolinear_ctrl

Sequencer for the `nolinear` non-linear function datapath (softmax, GELU/SiLU, root). It accepts one operation per command over a valid/ready handshake and latches the operand vector. It then drives the datapath mode and select/enable controls through one or two timed rounds. At the end of the final round it captures the datapath result and presents it on a valid/ready result port. It sits between the accelerator command queue and a single `nolinear` instance.

## Interface
- `FIX_POINT_WIDTH`, 16, width of one fixed-point element
- `DATA_NUM`, 4, elements per vector
- `R1_CYCLES`, 50, cycles spent in round 1 (≥1)
- `R2_CYCLES`, 1, cycles spent in round 2 (≥1)
- `clk`  in  1  clock; one clock domain
- `rst`  in  1  reset; asynchronous, active-low
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  command accepted when both high
- `cmd_op`  in  2  00 softmax, 01 gelu/silu, 10 root, 11 illegal
- `cmd_data`  in  DATA_NUM*FIX_POINT_WIDTH  operand vector
- `dp_mode`  out  2  to `nolinear.mode`
- `dp_in`  out  DATA_NUM*FIX_POINT_WIDTH  latched operand to `nolinear.in`
- `dp_s_in`  out  3;  `dp_s_mux`  out  1;  `dp_s_mult`  out  3;  `dp_s_add`  out  1;  `dp_en_mult`  out  1;  `dp_en_add`  out  1;  `dp_valid`  out  1  datapath controls
- `dp_out`  in  DATA_NUM*FIX_POINT_WIDTH  datapath result
- `res_valid`  out  1  result available
- `res_ready`  in  1  result consumed when both high
- `res_data`  out  DATA_NUM*FIX_POINT_WIDTH  captured result
- `res_err`  out  1  result is an illegal-op error, `res_data` = 0

## Operation
- States: IDLE, R1, R2, DONE. `cmd_ready` = (state==IDLE), and 0 while `rst` is low.
- IDLE: accept on `cmd_valid&&cmd_ready`. Latch `cmd_op` and `cmd_data`, then go to R1. Op 11 goes directly to DONE with `res_err`=1.
- Control words per (op, round). Fields listed as mode/s_in/s_mux/s_mult/s_add/en_mult/en_add/valid:
  - softmax R1: 00/0/1/2/1/1/0/0
  - softmax R2: 00/1/0/0/1/1/1/1
  - gelu R1: 01/2/1/4/0/1/0/0
  - gelu R2: 01/3/0/0/1/0/1/1
  - root R1: 10/2/0/1/0/1/0/1. Root has no R2.
- In IDLE and DONE, all `dp_*` controls are 0. `dp_in` holds the last latched operand.
- A down-counter is loaded with `R1_CYCLES-1` or `R2_CYCLES-1` on round entry. The round exits when the counter is 0.
- R1 exit: softmax and gelu go to R2; root goes to DONE.
- Final-round exit (R2, or R1 for root): capture `dp_out` into `res_data`, set `res_err`=0, go to DONE.
- DONE: hold `res_valid`=1 and `res_data` stable until `res_ready`, then go to IDLE.
- `cmd_valid` is ignored outside IDLE. A new command can be accepted at the earliest one cycle after the result handshake.

## Timing
- All outputs are registered except `cmd_ready`.
- Reset values: state IDLE; every `dp_*`, `res_valid`, `res_err` and `res_data` = 0.
- Reset asserted mid-operation: the operation is dropped immediately. No result is produced.
- Acceptance at edge T: R1 controls are visible from T+1 for exactly `R1_CYCLES` cycles. R2 controls follow for `R2_CYCLES` cycles.
- `res_valid` rises at T+1+R1_CYCLES+R2_CYCLES for two-round ops, and at T+1+R1_CYCLES for root. It rises at T+1 for op 11.
- `dp_out` is sampled on the edge that ends the last cycle of the final round.
- `res_ready` high while `res_valid` is low has no effect.

## Configuration
- `NL_CTRL_ABORT_EN` defined: adds input `abort` (1 bit).
  - `abort` high in R1 or R2 forces IDLE on the next edge. Controls go to 0 and no result is produced.
  - `abort` in DONE clears `res_valid`.
  - `abort` in IDLE has no effect.
- `NL_CTRL_ABORT_EN` not defined: no `abort` port. Operations always run to completion.

## Structure
- `nl_ctrl_pkg` contains:
  - op encodings
  - state enum
  - packed control-word struct (mode, s_in, s_mux, s_mult, s_add, en_mult, en_add, valid)
  - the five control-word constants and the idle word
- Sub-module `nl_ctrl_rom`: combinational lookup from (op, round) to the control word. The FSM registers its output.

## Test plan
- Softmax, `cmd_data`=0x0200020002000200, defaults:
  - controls 00/0/1/2/1/1/0/0 for 50 cycles, then 00/1/0/0/1/1/1/1 for 1 cycle
  - `res_valid` at T+52 with `res_data`=`dp_out` at capture
- GELU with `res_ready` held low for 10 cycles:
  - R1/R2 words as listed
  - `res_data` is stable throughout; `cmd_ready` stays 0 until one cycle after the handshake
- Root, `cmd_data`=0x0400090010001900:
  - single round 10/2/0/1/0/1/0/1 for 50 cycles
  - `res_valid` at T+51
- Op 11: `res_valid`=1 and `res_err`=1 at T+1, `res_data`=0, all `dp_*` stay 0.
- `rst` low at cycle 20 of softmax R1: all outputs are 0 immediately. After release, `cmd_ready`=1 and no stale result appears.
- With `NL_CTRL_ABORT_EN`, `abort` during R2: IDLE next edge, `res_valid` never rises, and the next command runs normally.
